dm_arbiter: RTL and testbench

- Two-port arbiter and access sequencer for the single-port data memory (word-addressed, combinational LoadData, write committed on clk rising edge).
- Shares the DM between requester 0 (CPU load/store path) and requester 1 (debug/IO loader) over a req/ack handshake.
- Provides round-robin fairness, a registered command stage and alignment/range checking.
- Sits between the requesters and the DM instance; it is the only driver of the DM's addr/StoreData/WriteEnable.

---
 rtl/dm_arb_pkg.sv | 15 +
 rtl/dm_arbiter_rr_arb2.sv | 21 ++
 rtl/dm_arbiter.sv | 131 +++++++++++++
 tb/tb_dm_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
// Imported by dm_arbiter and its round-robin sub-module.
package dm_arb_pkg;

    localparam int DM_WORDS_DEF = 1024;
    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// and on contention the requester that was not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter and access sequencer for the single-port data memory.
// One access per IDLE -> ACCESS -> RESP pass; the DM write happens at the end of ACCESS.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    // Handshake: a requester raises mX_req with we/addr/wdata stable and keeps
    // them stable until its one-cycle mX_ack; mX_err and mX_rdata are valid with
    // that ack. A req still high in the IDLE cycle after ack is a new request.
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_store_data,
    output logic              dm_write_enable,
    input  logic [DATA_W-1:0] dm_load_data
);

    localparam logic [ADDR_W-1:0] LP_WORDS = ADDR_W'(DM_WORDS);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_last_grant;
    logic              r_gnt_id;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_start;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_win_err;

    rr_arb2 u_rr (
        .req        ({m1_req, m0_req}),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_id     (w_gnt_id)
    );

    assign w_start     = (r_state == ST_IDLE) & w_gnt_valid;
    assign w_win_we    = w_gnt_id ? m1_we    : m0_we;
    assign w_win_addr  = w_gnt_id ? m1_addr  : m0_addr;
    assign w_win_wdata = w_gnt_id ? m1_wdata : m0_wdata;
    assign w_word_idx  = {2'b00, w_win_addr[ADDR_W-1:2]};
    assign w_win_err   = (|w_win_addr[1:0]) | (w_word_idx >= LP_WORDS);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_gnt_valid) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_gnt_id     <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_last_grant <= w_gnt_id;
                r_gnt_id     <= w_gnt_id;
                r_we         <= w_win_we;
                r_err        <= w_win_err;
                r_addr       <= w_win_addr;
                r_wdata      <= w_win_wdata;
            end
        end
    end

    // Load data is captured as ACCESS ends; rejected accesses return zero,
    // stores leave the previous load result in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (r_state == ST_ACCESS) begin
            if (r_err) begin
                if (r_gnt_id) r_m1_rdata <= '0;
                else          r_m0_rdata <= '0;
            end else if (!r_we) begin
                if (r_gnt_id) r_m1_rdata <= dm_load_data;
                else          r_m0_rdata <= dm_load_data;
            end
        end
    end

    assign dm_addr         = r_addr;
    assign dm_store_data   = r_wdata;
    assign dm_write_enable = (r_state == ST_ACCESS) & r_we & ~r_err;

    assign m0_ack   = (r_state == ST_RESP) & ~r_gnt_id;
    assign m1_ack   = (r_state == ST_RESP) &  r_gnt_id;
    assign m0_err   = m0_ack & r_err;
    assign m1_err   = m1_ack & r_err;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural single-port DM attached.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] dm_addr, dm_store_data, dm_load_data;
    logic        dm_write_enable;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:1023];

    dm_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .m0_req          (m0_req),
        .m0_we           (m0_we),
        .m0_addr         (m0_addr),
        .m0_wdata        (m0_wdata),
        .m0_ack          (m0_ack),
        .m0_err          (m0_err),
        .m0_rdata        (m0_rdata),
        .m1_req          (m1_req),
        .m1_we           (m1_we),
        .m1_addr         (m1_addr),
        .m1_wdata        (m1_wdata),
        .m1_ack          (m1_ack),
        .m1_err          (m1_err),
        .m1_rdata        (m1_rdata),
        .dm_addr         (dm_addr),
        .dm_store_data   (dm_store_data),
        .dm_write_enable (dm_write_enable),
        .dm_load_data    (dm_load_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge
    assign dm_load_data = mem[dm_addr[11:2]];
    always @(posedge clk) begin
        if (dm_write_enable) mem[dm_addr[11:2]] <= dm_store_data;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int port, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // Single access from IDLE with exact latency checks; returns in the next IDLE.
    task automatic do_access(input string tag, input int port, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic exp_err, input logic [31:0] exp_rdata);
        drive_req(port, 1'b1, we, addr, wdata);
        @(posedge clk); #1;
        check_val({tag, "_we"}, {31'd0, dm_write_enable}, {31'd0, we & ~exp_err});
        if (!exp_err) check_val({tag, "_dm_addr"}, dm_addr, addr);
        if (we && !exp_err) check_val({tag, "_dm_sd"}, dm_store_data, wdata);
        @(posedge clk); #1;
        check_val({tag, "_ack"}, {31'd0, (port == 0) ? m0_ack : m1_ack}, 32'd1);
        check_val({tag, "_other_ack"}, {31'd0, (port == 0) ? m1_ack : m0_ack}, 32'd0);
        check_val({tag, "_err"}, {31'd0, (port == 0) ? m0_err : m1_err}, {31'd0, exp_err});
        check_val({tag, "_rdata"}, (port == 0) ? m0_rdata : m1_rdata, exp_rdata);
        drive_req(port, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        apply_reset();

        check_val("rst_m0_ack",   {31'd0, m0_ack}, 32'd0);
        check_val("rst_m1_ack",   {31'd0, m1_ack}, 32'd0);
        check_val("rst_m0_err",   {31'd0, m0_err}, 32'd0);
        check_val("rst_m1_err",   {31'd0, m1_err}, 32'd0);
        check_val("rst_m0_rdata", m0_rdata, 32'd0);
        check_val("rst_m1_rdata", m1_rdata, 32'd0);
        check_val("rst_dm_addr",  dm_addr, 32'd0);
        check_val("rst_dm_sd",    dm_store_data, 32'd0);
        check_val("rst_dm_we",    {31'd0, dm_write_enable}, 32'd0);
        reset = 1'b1;

        // Preload through requester 1: last word and word 0x30
        do_access("pre_ffc", 1, 1'b1, 32'h0000_0FFC, 32'hCAFE_0001, 1'b0, 32'd0);
        do_access("pre_30",  1, 1'b1, 32'h0000_0030, 32'h0000_1234, 1'b0, 32'd0);

        // Write then read, m0 only
        do_access("m0_st10", 0, 1'b1, 32'h0000_0010, 32'd100, 1'b0, 32'd0);
        check_val("mem_10", mem[4], 32'd100);
        do_access("m0_ld10", 0, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'd100);

        // Contention right after reset goes to m0; m1 follows 3 cycles later
        apply_reset();
        check_val("rst2_m0_rdata", m0_rdata, 32'd0);
        reset = 1'b1;
        drive_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
        drive_req(1, 1'b1, 1'b1, 32'h0000_0020, 32'd7);
        @(posedge clk); #1;
        check_val("ct_dm_addr0", dm_addr, 32'h10);
        check_val("ct_we0", {31'd0, dm_write_enable}, 32'd0);
        @(posedge clk); #1;
        check_val("ct_m0_ack", {31'd0, m0_ack}, 32'd1);
        check_val("ct_m1_ack0", {31'd0, m1_ack}, 32'd0);
        check_val("ct_m0_rdata", m0_rdata, 32'd100);
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_val("ct_idle_m1_ack", {31'd0, m1_ack}, 32'd0);
        @(posedge clk); #1;
        check_val("ct_we1", {31'd0, dm_write_enable}, 32'd1);
        check_val("ct_dm_addr1", dm_addr, 32'h20);
        check_val("ct_dm_sd1", dm_store_data, 32'd7);
        @(posedge clk); #1;
        check_val("ct_m1_ack", {31'd0, m1_ack}, 32'd1);
        check_val("ct_m1_err", {31'd0, m1_err}, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_val("mem_20", mem[8], 32'd7);

        // Both held high: grants alternate m0, m1, m0
        drive_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
        drive_req(1, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
        for (int k = 0; k < 3; k++) begin
            repeat (2) @(posedge clk);
            #1;
            check_val($sformatf("alt%0d_m0_ack", k), {31'd0, m0_ack}, {31'd0, k != 1});
            check_val($sformatf("alt%0d_m1_ack", k), {31'd0, m1_ack}, {31'd0, k == 1});
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        check_val("alt_m0_rdata", m0_rdata, 32'd100);
        check_val("alt_m1_rdata", m1_rdata, 32'd7);
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;

        // Misaligned store is rejected and clears m1_rdata
        do_access("mis_12", 1, 1'b1, 32'h0000_0012, 32'hDEAD_BEEF, 1'b1, 32'd0);
        check_val("mis_mem_10", mem[4], 32'd100);

        // Range boundary: last word is valid, one past it is not
        do_access("rng_ffc",  0, 1'b0, 32'h0000_0FFC, 32'd0, 1'b0, 32'hCAFE_0001);
        do_access("rng_1000", 0, 1'b0, 32'h0000_1000, 32'd0, 1'b1, 32'd0);

        // Reset during ACCESS abandons the store
        drive_req(0, 1'b1, 1'b1, 32'h0000_0030, 32'd55);
        @(posedge clk); #1;
        check_val("rm_we_before", {31'd0, dm_write_enable}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("rm_we_async", {31'd0, dm_write_enable}, 32'd0);
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_val("rm_m0_ack", {31'd0, m0_ack}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rm_m0_ack2", {31'd0, m0_ack}, 32'd0);
        check_val("rm_mem_30", mem[12], 32'h0000_1234);
        do_access("rm_ld30", 0, 1'b0, 32'h0000_0030, 32'd0, 1'b0, 32'h0000_1234);

        // Back-to-back m0 stores with req held: ack every 3rd cycle
        drive_req(0, 1'b1, 1'b1, 32'h0000_0040, 32'd11);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk); #1;
            check_val($sformatf("b2b%0d_m0_ack", cyc), {31'd0, m0_ack}, {31'd0, (cyc % 3) == 2});
            check_val($sformatf("b2b%0d_m1_ack", cyc), {31'd0, m1_ack}, 32'd0);
            if ((cyc % 3) == 1)
                check_val($sformatf("b2b%0d_we", cyc), {31'd0, dm_write_enable}, 32'd1);
            if (cyc == 2) drive_req(0, 1'b1, 1'b1, 32'h0000_0044, 32'd22);
            if (cyc == 5) drive_req(0, 1'b1, 1'b1, 32'h0000_0048, 32'd33);
            if (cyc == 8) drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        check_val("b2b_mem_40", mem[16], 32'd11);
        check_val("b2b_mem_44", mem[17], 32'd22);
        check_val("b2b_mem_48", mem[18], 32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
